// File: rtl/mmio_pkg.sv
// Shared MMIO window definitions: base region, register offsets and the load-mux select decode.
package mmio_pkg;

  localparam logic [3:0] MMIO_BASE       = 4'h8;

  localparam logic [7:0] MMIO_UART_CTRL  = 8'h00;
  localparam logic [7:0] MMIO_UART_RX    = 8'h04;
  localparam logic [7:0] MMIO_UART_TX    = 8'h08;
  localparam logic [7:0] MMIO_CYCLE_CNT  = 8'h10;
  localparam logic [7:0] MMIO_INST_CNT   = 8'h14;
  localparam logic [7:0] MMIO_CNT_RST    = 8'h18;
  localparam logic [7:0] MMIO_BRANCH_CNT = 8'h1C;
  localparam logic [7:0] MMIO_FIFO_EMPTY = 8'h20;
  localparam logic [7:0] MMIO_FIFO_DATA  = 8'h24;
  localparam logic [7:0] MMIO_SWITCHES   = 8'h28;
  localparam logic [7:0] MMIO_LEDS       = 8'h30;

  typedef enum logic [3:0] {
    RD_NONE,
    RD_UART_CTRL,
    RD_UART_RX,
    RD_CYCLE_CNT,
    RD_INST_CNT,
    RD_BRANCH_CNT,
    RD_FIFO_EMPTY,
    RD_FIFO_DATA,
    RD_SWITCHES,
    RD_LEDS
  } rd_sel_e;

  // Map addr[31:28] and the word index addr[7:2] to a load-mux select.
  function automatic rd_sel_e rd_decode(input logic [3:0] region, input logic [5:0] word);
    rd_sel_e sel;
    sel = RD_NONE;
    if (region == MMIO_BASE) begin
      case ({word, 2'b00})
        MMIO_UART_CTRL:  sel = RD_UART_CTRL;
        MMIO_UART_RX:    sel = RD_UART_RX;
        MMIO_CYCLE_CNT:  sel = RD_CYCLE_CNT;
        MMIO_INST_CNT:   sel = RD_INST_CNT;
        MMIO_BRANCH_CNT: sel = RD_BRANCH_CNT;
        MMIO_FIFO_EMPTY: sel = RD_FIFO_EMPTY;
        MMIO_FIFO_DATA:  sel = RD_FIFO_DATA;
        MMIO_SWITCHES:   sel = RD_SWITCHES;
        MMIO_LEDS:       sel = RD_LEDS;
        default:         sel = RD_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/mmio_if.sv
// CPU-side MMIO load/store bus; master drives the request, slave returns registered load data.
interface mmio_if;
  logic [31:0] addr;
  logic        re;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, output re, output we, output wdata, input rdata);
  modport slave  (input addr, input re, input we, input wdata, output rdata);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and occupancy count; a pop frees room for a same-cycle push.
module sync_fifo #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout_c,
  output logic             full_c,
  output logic             empty_c,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty_c = (count == '0);
  assign full_c  = (count == (AW+1)'(DEPTH));
  assign dout_c  = mem[rd_ptr];
  assign do_pop  = pop && !empty_c;
  assign do_push = push && (!full_c || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_responder.sv
// MMIO slave for the 0x8000_00xx window: counters, UART glue, button-event FIFO, switches, LEDs.
// Define MMIO_BRANCH_CNT_EN to build the taken-branch counter at offset 1C.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned CPU_CLOCK_FREQ = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  mmio_if.slave       bus,
  input  logic        inst_retire,
  input  logic        br_taken,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [2:0]  clean_buttons,
  input  logic [1:0]  switches,
  output logic [5:0]  leds
);

  localparam int unsigned FIFO_AW = $clog2(FIFO_DEPTH);

  rd_sel_e          rd_sel;
  logic [7:0]       off;
  logic             base_hit;
  logic             st_tx;
  logic             st_cnt_rst;
  logic             st_leds;
  logic             ld_rx;
  logic             ld_fifo;
  logic [31:0]      rd_value;
  logic [31:0]      cycle_cnt;
  logic [31:0]      inst_cnt;
  logic [31:0]      cycle_inc;
  logic [31:0]      inst_inc;
  logic [2:0]       btn_q;
  logic [2:0]       btn_rise;
  logic [2:0]       fifo_head;
  logic             fifo_empty;
  logic             fifo_full;
  logic [FIFO_AW:0] fifo_count;
  logic             unused_bits;

  assign off        = {bus.addr[7:2], 2'b00};
  assign base_hit   = (bus.addr[31:28] == MMIO_BASE);
  assign rd_sel     = rd_decode(bus.addr[31:28], bus.addr[7:2]);
  assign st_tx      = bus.we && base_hit && (off == MMIO_UART_TX);
  assign st_cnt_rst = bus.we && base_hit && (off == MMIO_CNT_RST);
  assign st_leds    = bus.we && base_hit && (off == MMIO_LEDS);
  assign ld_rx      = bus.re && (rd_sel == RD_UART_RX);
  assign ld_fifo    = bus.re && (rd_sel == RD_FIFO_DATA);
  assign btn_rise   = clean_buttons & ~btn_q;

  // Counter loads return the value the counter takes at the capturing edge, ignoring a same-cycle clear.
  assign cycle_inc  = cycle_cnt + 32'd1;
  assign inst_inc   = inst_cnt + 32'(inst_retire);

`ifdef MMIO_BRANCH_CNT_EN
  logic [31:0] br_cnt;
  logic [31:0] br_inc;
  assign br_inc = br_cnt + 32'(br_taken);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            br_cnt <= '0;
    else if (st_cnt_rst) br_cnt <= '0;
    else                 br_cnt <= br_inc;
  end

  assign unused_bits = ^{bus.addr[27:8], bus.addr[1:0], bus.wdata[31:8], fifo_count,
                         fifo_full, 32'(CPU_CLOCK_FREQ)};
`else
  assign unused_bits = ^{bus.addr[27:8], bus.addr[1:0], bus.wdata[31:8], fifo_count,
                         fifo_full, 32'(CPU_CLOCK_FREQ), br_taken};
`endif

  always_comb begin
    rd_value = '0;
    case (rd_sel)
      RD_UART_CTRL:  rd_value = {30'b0, uart_rx_valid, uart_tx_ready};
      RD_UART_RX:    rd_value = {24'b0, uart_rx_data};
      RD_CYCLE_CNT:  rd_value = cycle_inc;
      RD_INST_CNT:   rd_value = inst_inc;
`ifdef MMIO_BRANCH_CNT_EN
      RD_BRANCH_CNT: rd_value = br_inc;
`endif
      RD_FIFO_EMPTY: rd_value = {31'b0, fifo_empty};
      RD_FIFO_DATA:  rd_value = fifo_empty ? 32'b0 : {29'b0, fifo_head};
      RD_SWITCHES:   rd_value = {30'b0, switches};
      RD_LEDS:       rd_value = {26'b0, leds};
      default:       rd_value = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.rdata     <= '0;
      cycle_cnt     <= '0;
      inst_cnt      <= '0;
      leds          <= '0;
      btn_q         <= '0;
      uart_rx_ready <= 1'b0;
      uart_tx_valid <= 1'b0;
      uart_tx_data  <= '0;
    end else begin
      if (bus.re) bus.rdata <= rd_value;
      if (st_cnt_rst) begin
        cycle_cnt <= '0;
        inst_cnt  <= '0;
      end else begin
        cycle_cnt <= cycle_inc;
        inst_cnt  <= inst_inc;
      end
      if (st_leds) leds <= bus.wdata[5:0];
      btn_q         <= clean_buttons;
      uart_rx_ready <= ld_rx;
      // A store with the transmitter busy is dropped rather than held.
      uart_tx_valid <= st_tx && uart_tx_ready;
      if (st_tx && uart_tx_ready) uart_tx_data <= bus.wdata[7:0];
    end
  end

  sync_fifo #(
    .WIDTH (3),
    .DEPTH (FIFO_DEPTH)
  ) u_btn_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (|btn_rise),
    .pop     (ld_fifo),
    .din     (btn_rise),
    .dout_c  (fifo_head),
    .full_c  (fifo_full),
    .empty_c (fifo_empty),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_mmio_responder.sv
// Directed-vector bench for mmio_responder; expectations are hand-computed per load/store sequence.
module tb_mmio_responder;
  import mmio_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_retire;
  logic        br_taken;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_ready;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;
  logic [2:0]  clean_buttons;
  logic [1:0]  switches;
  logic [5:0]  leds;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  mmio_if bus ();

  mmio_responder #(.FIFO_DEPTH(8), .CPU_CLOCK_FREQ(50_000_000)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .inst_retire   (inst_retire),
    .br_taken      (br_taken),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_ready (uart_rx_ready),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready),
    .clean_buttons (clean_buttons),
    .switches      (switches),
    .leds          (leds)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One bus cycle: request held across one rising edge, returns at the following falling edge.
  task automatic bus_op(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.re    = r;
    bus.we    = w;
    bus.wdata = d;
    @(negedge clk);
    bus.re = 1'b0;
    bus.we = 1'b0;
  endtask

  task automatic load(input logic [7:0] o);
    bus_op(1'b1, 1'b0, {24'h8000_00, o}, 32'h0);
  endtask

  task automatic store(input logic [7:0] o, input logic [31:0] d);
    bus_op(1'b0, 1'b1, {24'h8000_00, o}, d);
  endtask

  logic [2:0] btn_seq [9];
  logic [31:0] br_exp;

  initial begin
    btn_seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1, 3'd2};
    rst = 1'b0;
    bus.addr = '0; bus.re = 1'b0; bus.we = 1'b0; bus.wdata = '0;
    inst_retire = 1'b0; br_taken = 1'b0;
    uart_rx_data = '0; uart_rx_valid = 1'b0; uart_tx_ready = 1'b0;
    clean_buttons = '0; switches = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_rdata", bus.rdata, 32'h0);
    check_eq("rst_leds", 32'(leds), 32'h0);
    check_eq("rst_tx_valid", 32'(uart_tx_valid), 32'h0);
    check_eq("rst_rx_ready", 32'(uart_rx_ready), 32'h0);
    rst = 1'b1;

    // 22 edges elapse, the load in the 23rd cycle reports 23; 21 of those cycles retire.
    for (int i = 0; i < 22; i++) begin
      inst_retire = (i < 21);
      @(negedge clk);
    end
    inst_retire = 1'b0;
    load(MMIO_CYCLE_CNT);
    check_eq("cycle_cnt_23", bus.rdata, 32'd23);
    load(MMIO_INST_CNT);
    check_eq("inst_cnt_21", bus.rdata, 32'd21);

    store(MMIO_CNT_RST, 32'h0);
    load(MMIO_CYCLE_CNT);
    check_eq("cycle_after_clr", bus.rdata, 32'd1);
    load(MMIO_INST_CNT);
    check_eq("inst_after_clr", bus.rdata, 32'd0);
    @(negedge clk);
    check_eq("rdata_hold", bus.rdata, 32'd0);

    force dut.inst_cnt = 32'hFFFF_FFFF;
    inst_retire = 1'b1;
    load(MMIO_INST_CNT);
    check_eq("inst_wrap", bus.rdata, 32'h0);
    release dut.inst_cnt;
    inst_retire = 1'b0;
    store(MMIO_CNT_RST, 32'h0);

    load(MMIO_FIFO_EMPTY);
    check_eq("fifo_empty_idle", bus.rdata, 32'd1);
    clean_buttons = 3'b111;
    @(negedge clk);
    load(MMIO_FIFO_EMPTY);
    check_eq("fifo_nonempty", bus.rdata, 32'd0);
    load(MMIO_FIFO_DATA);
    check_eq("fifo_pop_7", bus.rdata, 32'd7);
    load(MMIO_FIFO_EMPTY);
    check_eq("fifo_empty_after_pop", bus.rdata, 32'd1);

    // Nine rising edges into an 8-deep FIFO: the ninth is dropped.
    clean_buttons = 3'b000;
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      clean_buttons = btn_seq[i];
      @(negedge clk);
      clean_buttons = 3'b000;
      @(negedge clk);
    end
    load(MMIO_FIFO_EMPTY);
    check_eq("fifo_full_nonempty", bus.rdata, 32'd0);
    for (int i = 0; i < 9; i++) begin
      load(MMIO_FIFO_DATA);
      check_eq($sformatf("fifo_pop_%0d", i), bus.rdata, (i < 8) ? 32'(btn_seq[i]) : 32'd0);
    end
    load(MMIO_FIFO_EMPTY);
    check_eq("fifo_drained", bus.rdata, 32'd1);

    // Pop on empty with a same-cycle push: pop reads 0, push lands.
    clean_buttons = 3'b101;
    load(MMIO_FIFO_DATA);
    check_eq("empty_push_pop_rd", bus.rdata, 32'd0);
    clean_buttons = 3'b000;
    load(MMIO_FIFO_EMPTY);
    check_eq("empty_push_pop_cnt", bus.rdata, 32'd0);
    load(MMIO_FIFO_DATA);
    check_eq("empty_push_pop_val", bus.rdata, 32'd5);

    uart_tx_ready = 1'b1;
    store(MMIO_UART_TX, 32'h0000_1241);
    check_eq("tx_valid_pulse", 32'(uart_tx_valid), 32'd1);
    check_eq("tx_data", 32'(uart_tx_data), 32'h41);
    @(negedge clk);
    check_eq("tx_valid_end", 32'(uart_tx_valid), 32'd0);
    uart_tx_ready = 1'b0;
    store(MMIO_UART_TX, 32'h0000_0055);
    check_eq("tx_dropped", 32'(uart_tx_valid), 32'd0);
    check_eq("tx_data_kept", 32'(uart_tx_data), 32'h41);

    uart_rx_valid = 1'b1;
    load(MMIO_UART_CTRL);
    check_eq("uart_status", bus.rdata, 32'd2);
    uart_rx_data = 8'hC3;
    load(MMIO_UART_RX);
    check_eq("rx_byte", bus.rdata, 32'hC3);
    check_eq("rx_ready_pulse", 32'(uart_rx_ready), 32'd1);
    @(negedge clk);
    check_eq("rx_ready_end", 32'(uart_rx_ready), 32'd0);
    uart_rx_valid = 1'b0;

    switches = 2'b10;
    load(MMIO_SWITCHES);
    check_eq("switches", bus.rdata, 32'd2);

    store(MMIO_LEDS, 32'hFFFF_FF2A);
    check_eq("leds_store", 32'(leds), 32'h2A);
    load(MMIO_LEDS);
    check_eq("leds_readback", bus.rdata, 32'h2A);
    bus_op(1'b1, 1'b1, 32'h8000_0030, 32'h15);
    check_eq("rw_pre_store", bus.rdata, 32'h2A);
    check_eq("rw_leds", 32'(leds), 32'h15);

    load(8'h0C);
    check_eq("unmapped_rd", bus.rdata, 32'h0);
    bus_op(1'b1, 1'b0, 32'h0000_0030, 32'h0);
    check_eq("off_region_rd", bus.rdata, 32'h0);
    bus_op(1'b0, 1'b1, 32'h0000_0030, 32'h3F);
    check_eq("off_region_wr", 32'(leds), 32'h15);

    for (int i = 0; i < 5; i++) begin
      br_taken = 1'b1;
      @(negedge clk);
    end
    br_taken = 1'b0;
`ifdef MMIO_BRANCH_CNT_EN
    br_exp = 32'd5;
`else
    br_exp = 32'd0;
`endif
    load(MMIO_BRANCH_CNT);
    check_eq("branch_cnt", bus.rdata, br_exp);

    // Reset landing mid-cycle clears state without waiting for an edge.
    bus.addr = 32'h8000_0030;
    bus.re = 1'b1;
    #2 rst = 1'b0;
    #1;
    check_eq("async_rst_leds", 32'(leds), 32'h0);
    check_eq("async_rst_rdata", bus.rdata, 32'h0);
    bus.re = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    load(MMIO_LEDS);
    check_eq("post_rst_leds_rd", bus.rdata, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
